// File: rtl/lcd_req_sched_pkg.sv
// lcd_req_sched_pkg
// Shared types and constants for the LCD request scheduler:
//   OPCODE_W / VALUE_W / ENTRY_W : field widths of a queued display request
//   state_t                      : scheduler FSM state encoding
//   req_entry_t                  : FIFO entry layout {opcode[18:16], value[15:0]}
package lcd_req_sched_pkg;

  localparam int OPCODE_W = 3;
  localparam int VALUE_W  = 16;
  localparam int ENTRY_W  = OPCODE_W + VALUE_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_LOW       = 3'd2,
    ST_HIGH      = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [VALUE_W-1:0]  value;
  } req_entry_t;

endpackage

// File: rtl/lcd_req_sched_fifo.sv
// lcd_req_fifo
// Synchronous show-ahead FIFO of DEPTH request entries (DEPTH a power of 2).
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din at the clock edge (ignored when full unless popping)
//   pop/dout : dout always shows the head; pop advances it (ignored when empty)
//   level    : current occupancy, 0..DEPTH
//   full     : level == DEPTH
//   empty    : level == 0
module lcd_req_fifo
  import lcd_req_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ENTRY_W-1:0]    din,
  output logic [ENTRY_W-1:0]    dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               do_push, do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers are AW bits wide, so the increments wrap modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lcd_req_sched.sv
// lcd_req_sched
// Queues display requests from two sources, arbitrates them round-robin and
// drives the LCD writer one transaction at a time via a single send edge.
//   clk, rst                 : clock, synchronous active-high reset
//   a_req/a_opcode/a_value   : source A request (held until a_ack)
//   a_ack                    : one-cycle accept pulse to A
//   b_*                      : same for source B
//   lcd_ready                : writer idle (1) / busy (0)
//   lcd_send                 : writer send_key, idle high, latched on rise
//   lcd_opcode / lcd_value   : transaction fields, stable for the whole transaction
//   fifo_level               : current queue occupancy
//   err_timeout              : sticky, writer never went busy after an edge
module lcd_req_sched
  import lcd_req_sched_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req,
  input  logic [OPCODE_W-1:0]    a_opcode,
  input  logic [VALUE_W-1:0]     a_value,
  output logic                   a_ack,
  input  logic                   b_req,
  input  logic [OPCODE_W-1:0]    b_opcode,
  input  logic [VALUE_W-1:0]     b_value,
  output logic                   b_ack,
  input  logic                   lcd_ready,
  output logic                   lcd_send,
  output logic [OPCODE_W-1:0]    lcd_opcode,
  output logic [VALUE_W-1:0]     lcd_value,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic                send_q, send_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [VALUE_W-1:0]  value_q, value_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic                rr_b_q, rr_b_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, space;
  logic       a_elig, b_elig, grant_a, grant_b;
  req_entry_t push_entry, pop_entry;

  lcd_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (pop_entry),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && lcd_ready;
  assign space    = !fifo_full || fifo_pop;
  // A source's req is ignored while its ack is showing, so a requester that
  // drops req one cycle after the ack is never enqueued twice.
  assign a_elig   = a_req && !a_ack_q && space;
  assign b_elig   = b_req && !b_ack_q && space;

  // rr_b_q selects who wins a tie; the pointer always moves off the winner.
  always_comb begin
    grant_a    = a_elig && (!b_elig || !rr_b_q);
    grant_b    = b_elig && !grant_a;
    rr_b_d     = rr_b_q;
    if (grant_a) rr_b_d = 1'b1;
    if (grant_b) rr_b_d = 1'b0;
    a_ack_d    = grant_a;
    b_ack_d    = grant_b;
    fifo_push  = grant_a || grant_b;
    push_entry = grant_a ? '{opcode: a_opcode, value: a_value}
                         : '{opcode: b_opcode, value: b_value};
  end

  // The HIGH cycle is the first cycle after the send edge and WAIT_BUSY's
  // counter starts at zero on the next one, so the timeout lands exactly
  // BUSY_TIMEOUT cycles after the edge.
  always_comb begin
    state_d  = state_q;
    send_d   = send_q;
    opcode_d = opcode_q;
    value_d  = value_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          opcode_d = pop_entry.opcode;
          value_d  = pop_entry.value;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        send_d  = 1'b0;
        state_d = ST_LOW;
      end
      ST_LOW: begin
        send_d  = 1'b1;
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!lcd_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 2)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      send_q   <= 1'b1;
      opcode_q <= '0;
      value_q  <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      rr_b_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      send_q   <= send_d;
      opcode_q <= opcode_d;
      value_q  <= value_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      rr_b_q   <= rr_b_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign lcd_send    = send_q;
  assign lcd_opcode  = opcode_q;
  assign lcd_value   = value_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lcd_req_sched.sv
// tb_lcd_req_sched
// Directed bench for lcd_req_sched: a per-cycle vector table for basic
// request/transaction timing, then hand-written sequences for arbitration,
// FIFO full, a long writer init, writer timeout and reset mid-transaction.
// A small writer model watches lcd_send, records every latched transaction
// and drives lcd_ready.
module tb_lcd_req_sched;
  import lcd_req_sched_pkg::*;

  localparam int DEPTH        = 4;
  localparam int BUSY_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [2:0]  a_opcode = '0, b_opcode = '0;
  logic [15:0] a_value = '0, b_value = '0;
  logic        a_ack, b_ack;
  logic        lcd_ready = 1'b1;
  logic        lcd_send;
  logic [2:0]  lcd_opcode;
  logic [15:0] lcd_value;
  logic [2:0]  fifo_level;
  logic        err_timeout;

  always #5 clk = ~clk;

  lcd_req_sched #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_req       (a_req),
    .a_opcode    (a_opcode),
    .a_value     (a_value),
    .a_ack       (a_ack),
    .b_req       (b_req),
    .b_opcode    (b_opcode),
    .b_value     (b_value),
    .b_ack       (b_ack),
    .lcd_ready   (lcd_ready),
    .lcd_send    (lcd_send),
    .lcd_opcode  (lcd_opcode),
    .lcd_value   (lcd_value),
    .fifo_level  (fifo_level),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  // Writer model: goes busy for wr_busy_len cycles starting the cycle after
  // each rising edge of lcd_send (unless wr_ignore), holds lcd_ready low
  // while wr_hold is set. Runs 2ns after the edge so the main process
  // (1ns after the edge) can change its controls for the current cycle.
  int          wr_busy_len = 1;
  bit          wr_hold = 1'b0;
  bit          wr_ignore = 1'b0;
  int          busy_cnt = 0;
  logic        send_prev = 1'b1;
  int          low_len = 0;
  int          cyc = 0;
  logic [2:0]  cap_op[$];
  logic [15:0] cap_val[$];
  int          rise_cyc[$];

  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      busy_cnt  = 0;
      lcd_ready = !wr_hold;
      send_prev = 1'b1;
      low_len   = 0;
    end else begin
      if (busy_cnt > 0) begin
        lcd_ready = 1'b0;
        busy_cnt--;
      end else begin
        lcd_ready = !wr_hold;
      end
      if (lcd_send === 1'b0) low_len++;
      if (lcd_send === 1'b1 && send_prev === 1'b0) begin
        cap_op.push_back(lcd_opcode);
        cap_val.push_back(lcd_value);
        rise_cyc.push_back(cyc);
        checkOutput("send_low_cycles", low_len, 1);
        low_len = 0;
        if (!wr_ignore) busy_cnt = wr_busy_len;
      end
      send_prev = lcd_send;
    end
  end

  typedef struct {
    logic        a_req;
    logic [2:0]  a_op;
    logic [15:0] a_val;
    logic        b_req;
    logic [2:0]  b_op;
    logic [15:0] b_val;
    logic        e_a_ack;
    logic        e_b_ack;
    logic        e_send;
    logic [2:0]  e_level;
    logic [2:0]  e_op;
    logic [15:0] e_val;
  } vec_t;

  function automatic vec_t mk(logic ar, logic [2:0] ao, logic [15:0] av,
                              logic br, logic [2:0] bo, logic [15:0] bv,
                              logic ea, logic eb, logic es, logic [2:0] el,
                              logic [2:0] eo, logic [15:0] ev);
    vec_t v;
    v.a_req = ar; v.a_op = ao; v.a_val = av;
    v.b_req = br; v.b_op = bo; v.b_val = bv;
    v.e_a_ack = ea; v.e_b_ack = eb; v.e_send = es;
    v.e_level = el; v.e_op = eo; v.e_val = ev;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst   = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    cap_op.delete();
    cap_val.delete();
    rise_cyc.delete();
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    a_req = v.a_req; a_opcode = v.a_op; a_value = v.a_val;
    b_req = v.b_req; b_opcode = v.b_op; b_value = v.b_val;
    step();
    checkOutput($sformatf("row%0d_a_ack", idx), a_ack, v.e_a_ack);
    checkOutput($sformatf("row%0d_b_ack", idx), b_ack, v.e_b_ack);
    checkOutput($sformatf("row%0d_send", idx), lcd_send, v.e_send);
    checkOutput($sformatf("row%0d_level", idx), fifo_level, v.e_level);
    checkOutput($sformatf("row%0d_opcode", idx), lcd_opcode, v.e_op);
    checkOutput($sformatf("row%0d_value", idx), lcd_value, v.e_val);
  endtask

  task automatic waitCaptures(input string name, input int n, input int budget);
    int k = 0;
    while (cap_op.size() < n && k < budget) begin
      step();
      k++;
    end
    checkOutput({name, "_captures"}, cap_op.size(), n);
  endtask

  task automatic checkCapture(input string name, input int idx,
                              input logic [2:0] op, input logic [15:0] val);
    if (cap_op.size() > idx) begin
      checkOutput($sformatf("%s_op%0d", name, idx), cap_op[idx], op);
      checkOutput($sformatf("%s_val%0d", name, idx), cap_val[idx], val);
    end
  endtask

  vec_t tbl[17];

  initial begin
    bit all_high;
    int n_before;

    tbl[0]  = mk(1, 3'd1, 16'd12345, 0, 3'd0, 16'h0, 1, 0, 1, 3'd1, 3'd0, 16'd0);
    tbl[1]  = mk(1, 3'd1, 16'd12345, 0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd1, 16'd12345);
    tbl[2]  = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 0, 3'd0, 3'd1, 16'd12345);
    tbl[3]  = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd1, 16'd12345);
    tbl[4]  = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd1, 16'd12345);
    tbl[5]  = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd1, 16'd12345);
    tbl[6]  = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd1, 16'd12345);
    tbl[7]  = mk(1, 3'd5, 16'd255,   0, 3'd0, 16'h0, 1, 0, 1, 3'd1, 3'd1, 16'd12345);
    tbl[8]  = mk(1, 3'd5, 16'd255,   0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd5, 16'd255);
    tbl[9]  = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 0, 3'd0, 3'd5, 16'd255);
    tbl[10] = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd5, 16'd255);
    tbl[11] = mk(0, 3'd0, 16'd0,     1, 3'd6, 16'hBEEF, 0, 1, 1, 3'd1, 3'd5, 16'd255);
    tbl[12] = mk(0, 3'd0, 16'd0,     1, 3'd6, 16'hBEEF, 0, 0, 1, 3'd1, 3'd5, 16'd255);
    tbl[13] = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd1, 3'd5, 16'd255);
    tbl[14] = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd6, 16'hBEEF);
    tbl[15] = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 0, 3'd0, 3'd6, 16'hBEEF);
    tbl[16] = mk(0, 3'd0, 16'd0,     0, 3'd0, 16'h0, 0, 0, 1, 3'd0, 3'd6, 16'hBEEF);

    // Reset state
    wr_busy_len = 1;
    resetDut();
    checkOutput("rst_send", lcd_send, 1);
    checkOutput("rst_opcode", lcd_opcode, 0);
    checkOutput("rst_value", lcd_value, 0);
    checkOutput("rst_a_ack", a_ack, 0);
    checkOutput("rst_b_ack", b_ack, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_err", err_timeout, 0);

    // Single requests from A then B, prompt writer, cycle by cycle
    $display("[TB] table: single requests");
    for (int i = 0; i < 17; i++) applyStimulus(i, tbl[i]);
    waitCaptures("table", 3, 50);
    checkCapture("table", 0, 3'd1, 16'd12345);
    checkCapture("table", 1, 3'd5, 16'd255);
    checkCapture("table", 2, 3'd6, 16'hBEEF);

    // Simultaneous A and B with pointer at A, writer busy 3 cycles
    $display("[TB] sequence: simultaneous A/B");
    wr_busy_len = 3;
    resetDut();
    a_req = 1; a_opcode = 3'd2; a_value = 16'd7;
    b_req = 1; b_opcode = 3'd3; b_value = 16'd9;
    step();
    checkOutput("rr_first_a_ack", a_ack, 1);
    checkOutput("rr_first_b_ack", b_ack, 0);
    a_req = 0;
    step();
    checkOutput("rr_second_a_ack", a_ack, 0);
    checkOutput("rr_second_b_ack", b_ack, 1);
    b_req = 0;
    waitCaptures("rr", 2, 100);
    checkCapture("rr", 0, 3'd2, 16'd7);
    checkCapture("rr", 1, 3'd3, 16'd9);
    if (rise_cyc.size() >= 2)
      checkOutput("rr_edge_gap", rise_cyc[1] - rise_cyc[0], 5 + 3);

    // Fill the FIFO while the writer is held busy
    $display("[TB] sequence: FIFO full");
    wr_busy_len = 1;
    wr_hold = 1;
    resetDut();
    a_req = 1; a_opcode = 3'd7;
    for (int i = 0; i < DEPTH; i++) begin
      a_value = 16'(100 + i);
      step();
      checkOutput($sformatf("full_push%0d_ack", i), a_ack, 1);
      step();
      checkOutput($sformatf("full_gap%0d_ack", i), a_ack, 0);
    end
    checkOutput("full_level", fifo_level, DEPTH);
    a_value = 16'd104;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput($sformatf("full_hold%0d_ack", i), a_ack, 0);
      checkOutput($sformatf("full_hold%0d_level", i), fifo_level, DEPTH);
    end
    wr_hold = 0;
    step();
    checkOutput("full_poppush_ack", a_ack, 1);
    checkOutput("full_poppush_level", fifo_level, DEPTH);
    a_req = 0;
    waitCaptures("full", 5, 200);
    for (int i = 0; i < 5; i++) checkCapture("full", i, 3'd7, 16'(100 + i));

    // Writer still initialising for 1000 cycles with two requests queued
    $display("[TB] sequence: long writer init");
    wr_hold = 1;
    resetDut();
    a_req = 1; a_opcode = 3'd1; a_value = 16'h1111;
    b_req = 1; b_opcode = 3'd2; b_value = 16'h2222;
    step();
    a_req = 0;
    step();
    b_req = 0;
    all_high = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (lcd_send !== 1'b1) all_high = 1'b0;
    end
    checkOutput("init_send_held_high", all_high, 1);
    checkOutput("init_level", fifo_level, 2);
    wr_hold = 0;
    step();
    checkOutput("init_load_send", lcd_send, 1);
    step();
    checkOutput("init_low_send", lcd_send, 0);
    waitCaptures("init", 2, 100);
    checkCapture("init", 0, 3'd1, 16'h1111);
    checkCapture("init", 1, 3'd2, 16'h2222);

    // Writer ignores the edge: timeout, drop, next request still issued
    $display("[TB] sequence: writer timeout");
    wr_ignore = 1;
    resetDut();
    a_req = 1; a_opcode = 3'd3; a_value = 16'h0A0A;
    b_req = 1; b_opcode = 3'd4; b_value = 16'h0B0B;
    for (int n = 0; n <= 14; n++) begin
      step();
      if (n == 0) a_req = 0;
      if (n == 1) b_req = 0;
      if (n == 10) checkOutput("to_err_before", err_timeout, 0);
      if (n == 11) checkOutput("to_err_set", err_timeout, 1);
      if (n == 12) checkOutput("to_level_after_pop", fifo_level, 0);
      if (n == 13) checkOutput("to_next_low", lcd_send, 0);
      if (n == 14) checkOutput("to_next_high", lcd_send, 1);
    end
    for (int n = 0; n < 10; n++) step();
    checkOutput("to_captures", cap_op.size(), 2);
    checkCapture("to", 1, 3'd4, 16'h0B0B);

    // Reset while in WAIT_DONE with three entries queued
    $display("[TB] sequence: reset mid-transaction");
    wr_ignore = 0;
    wr_busy_len = 20;
    cap_op.delete();
    cap_val.delete();
    rise_cyc.delete();
    checkOutput("mid_err_sticky", err_timeout, 1);
    a_req = 1; a_opcode = 3'd1; a_value = 16'h0001;
    b_req = 1; b_opcode = 3'd2; b_value = 16'h0002;
    step();
    a_value = 16'h0003;
    step();
    b_value = 16'h0004;
    step();
    a_req = 0;
    step();
    b_req = 0;
    checkOutput("mid_level", fifo_level, 3);
    step();
    step();
    step();
    rst = 1;
    step();
    checkOutput("mid_rst_send", lcd_send, 1);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_err", err_timeout, 0);
    checkOutput("mid_rst_opcode", lcd_opcode, 0);
    rst = 0;
    n_before = cap_op.size();
    checkOutput("mid_edges_before", n_before, 1);
    all_high = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (lcd_send !== 1'b1) all_high = 1'b0;
    end
    checkOutput("mid_no_more_edges", cap_op.size(), 1);
    checkOutput("mid_send_high", all_high, 1);
    checkOutput("mid_level_after", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_req_sched.md
Name: lcd_req_sched

Overview:
- Request scheduler in front of the LCD display writer (single-transaction engine: latches opcode + 16-bit register value on a rising edge of its send_key input; busy while its fsm_done is low).
- Accepts display requests from two sources: A = instruction-execute path, B = debug/status source.
- Buffers requests in a small FIFO and arbitrates round-robin.
- Issues one send edge per request, spaced so the writer never sees an edge while busy. Flags a writer that fails to start.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16).
- BUSY_TIMEOUT, 8, cycles allowed after the send edge for lcd_ready to fall.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a_req  in  1  source A request, held until acked
- a_opcode  in  3  source A opcode
- a_value  in  16  source A register value
- a_ack  out  1  one-cycle accept pulse to A
- b_req, b_opcode, b_value, b_ack: as the A ports, for source B
- lcd_ready  in  1  writer fsm_done (1 = idle)
- lcd_send  out  1  to writer send_key (idle high)
- lcd_opcode  out  3  to writer opcode
- lcd_value  out  16  to writer reg_value
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- err_timeout  out  1  sticky: writer failed to go busy

Behaviour:
Reset values:
- lcd_send=1; lcd_opcode=0; lcd_value=0; a_ack=b_ack=0; fifo_level=0; err_timeout=0.
- FSM=IDLE; round-robin pointer=A.
- Reset mid-transaction abandons it and empties the FIFO. lcd_send returns high.

Enqueue (every cycle, independent of the FSM):
- Eligible = req high, not acked in the previous cycle, and FIFO not full after this cycle's pop.
- Both eligible: the RR-pointer source wins. The pointer then moves to the other source.
- Single eligible: that source wins. The pointer moves to the other source.
- Winner gets ack high for 1 cycle; entry {opcode,value} is written at that edge.
- Full FIFO: no ack; the requester holds req. No drops, no overflow.
- Simultaneous push+pop on a full FIFO is allowed: level unchanged, ack issued.
- Ack-suppression rule: a requester may deassert req one cycle after ack. Its req is ignored in the cycle after its own ack, so a lingering req never double-enqueues.

FSM:
- IDLE: if FIFO non-empty and lcd_ready=1, pop the head into lcd_opcode/lcd_value, keep lcd_send=1, go LOAD. Otherwise wait. lcd_ready low at power-up, during writer init, holds here.
- LOAD (1 cycle): outputs stable; lcd_send=1. Go LOW.
- LOW (1 cycle): lcd_send=0. Go HIGH.
- HIGH: lcd_send=1. This is the rising edge the writer latches. Clear timeout counter. Go WAIT_BUSY.
- WAIT_BUSY: count cycles.
  - lcd_ready=0: go WAIT_DONE.
  - Counter reaches BUSY_TIMEOUT with lcd_ready still 1: set err_timeout, go IDLE. The request is discarded, not retried.
- WAIT_DONE: wait for lcd_ready=1, then go IDLE.

Invariants:
- lcd_opcode/lcd_value change only on the IDLE→LOAD pop and are stable through WAIT_DONE.
- lcd_send is low exactly 1 cycle per transaction.
- Minimum gap: with a prompt writer (busy 1 cycle after the edge), edge-to-edge ≥ 5 cycles plus writer busy time.
- FIFO pointers wrap modulo DEPTH.
- fifo_level = pushes − pops and never exceeds DEPTH.
- err_timeout clears only on rst.

Decomposition:
- Shared package holds:
  - opcode width 3; value width 16;
  - FSM state encoding (IDLE, LOAD, LOW, HIGH, WAIT_BUSY, WAIT_DONE);
  - request entry layout {opcode[18:16], value[15:0]}.
- One sub-module: lcd_req_fifo (synchronous FIFO, DEPTH×19). Ports push/pop/din/dout/level/full/empty; pop and push may happen in the same cycle.
- Arbiter and FSM stay in the top module.

Test Plan:
- Single A request (opcode 3'b001, value 12345), writer model busy 1 cycle after edge for 50 cycles:
  - a_ack 1 cycle after req;
  - lcd_send low exactly 1 cycle;
  - writer captures 001/12345;
  - FSM back in IDLE after lcd_ready rises.
- A and B request in the same cycle (A=010/7, B=011/9), pointer=A:
  - A acked first, B next eligible cycle;
  - writer receives 010/7 then 011/9;
  - the second edge only after lcd_ready returns high.
- Fill FIFO (DEPTH=4) from A with writer held busy (lcd_ready=0):
  - 4 acks, fifo_level=4;
  - 5th req held without ack;
  - release lcd_ready: 5th acked in the pop cycle, and all 5 values delivered in order.
- lcd_ready low from reset for 1000 cycles with 2 queued requests:
  - lcd_send stays 1;
  - first edge within 2 cycles of lcd_ready rising.
- Writer model ignores the edge (lcd_ready stays 1):
  - err_timeout set BUSY_TIMEOUT cycles after the edge;
  - entry dropped;
  - next queued request still issued.
- Assert rst in WAIT_DONE with 3 entries queued:
  - next cycle lcd_send=1, fifo_level=0, err_timeout=0;
  - no further edges.
